mem_access: RTL

Memory-access stage of the RV32I_Zicsr five-stage pipeline, between the ALU stage and writeback. It takes the ALU result, store data and decoded load/store information, and runs one Wishbone pipelined-mode transaction per load or store. For loads it realigns and sign- or zero-extends the returned data. Non-memory instructions pass through to writeback in one cycle. It detects misaligned accesses and bus timeouts, and stalls the upstream stages while a transaction is outstanding.

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access_align.sv | 63 ++++++
 rtl/mem_access.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: funct3 widths, Wishbone byte-lane
// patterns, FSM state type and the misalignment rule.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B    = 4'b0001;
  localparam logic [3:0] SEL_H    = 4'b0011;
  localparam logic [3:0] SEL_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bytes never fault; halfwords need addr[0]=0; words need addr[1:0]=00.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = a[0];
      2'b10:   r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store byte-enables / replicated data and
// load byte/halfword extraction with sign or zero extension.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_sel   = SEL_W;
    o_wdata = i_rs2;
    if (i_is_store) begin
      case (i_funct3)
        F3_B: begin
          o_sel   = SEL_B << i_addr_lo;
          o_wdata = {4{i_rs2[7:0]}};
        end
        F3_H: begin
          o_sel   = SEL_H << i_addr_lo;
          o_wdata = {2{i_rs2[15:0]}};
        end
        default: begin
          o_sel   = SEL_W;
          o_wdata = i_rs2;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'd0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'd0, w_half};
      F3_W:    o_ldata = i_rdata;
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one Wishbone pipelined transaction per load/store,
// load realignment, misalignment and ack-timeout detection, upstream stall.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_wr_rd,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data,
  output logic        o_ce,
  output logic        o_wr_rd,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd,
  output logic [31:0] o_pc,
  output logic        o_misaligned,
  output logic        o_bus_error,
  output logic        o_stall,
  output logic        o_flush,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  // Handshake: a request is accepted on a cycle with stb=1 and stall=0; the slave
  // answers with one ack, either in that same cycle or later while cyc stays high.

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [2:0]         r_funct3;
  logic               r_is_store;
  logic [31:0]        r_rs2;
  logic [31:0]        r_rd;
  logic [4:0]         r_rd_addr;
  logic               r_wr_rd;
  logic [31:0]        r_pc;
  logic               r_killed;

  logic               w_launch;
  logic               w_mem_op;
  logic               w_mis;
  logic               w_start;
  logic               w_timeout;
  logic               w_ack_ok;
  logic               w_to;
  logic               w_cyc;
  logic [3:0]         w_sel;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ldata;

  assign w_launch  = i_ce & ~i_stall & ~i_flush & (r_state == ST_IDLE);
  assign w_mem_op  = i_is_load | i_is_store;
  assign w_mis     = is_misaligned(i_funct3, i_addr[1:0]);
  assign w_start   = w_launch & w_mem_op & ~w_mis;
  assign w_timeout = (ACK_TIMEOUT != 0) && ((int'(r_cnt) + 1) == ACK_TIMEOUT);

  mem_align u_align (
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .i_is_store (r_is_store),
    .i_rs2      (r_rs2),
    .i_rdata    (i_wb_data),
    .o_sel      (w_sel),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) r_cnt <= r_cnt + CNT_W'(1);
      else                                              r_cnt <= '0;
    end
  end

  // An ack coincident with the final timeout cycle wins over the timeout.
  always_comb begin
    w_next   = r_state;
    w_ack_ok = 1'b0;
    w_to     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ: begin
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            w_next   = ST_DONE;
            w_ack_ok = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_wb_ack) begin
          w_next   = ST_DONE;
          w_ack_ok = 1'b1;
        end else if (w_timeout) begin
          w_next = ST_DONE;
          w_to   = 1'b1;
        end
      end
      ST_DONE: if (!i_stall) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from the state register so reset drops them at once.
  assign w_cyc       = (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign o_wb_cyc    = w_cyc;
  assign o_wb_stb    = (r_state == ST_REQ);
  assign o_wb_we     = w_cyc & r_is_store;
  assign o_wb_addr   = w_cyc ? {r_addr[31:2], 2'b00} : 32'd0;
  assign o_wb_sel    = w_cyc ? w_sel : SEL_NONE;
  assign o_wb_data   = w_cyc ? w_wdata : 32'd0;
  assign o_stall     = (r_state != ST_IDLE) | i_stall;
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_funct3   <= '0;
      r_is_store <= 1'b0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rd_addr  <= '0;
      r_wr_rd    <= 1'b0;
      r_pc       <= '0;
      r_killed   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr     <= i_addr;
        r_funct3   <= i_funct3;
        r_is_store <= i_is_store;
        r_rs2      <= i_rs2;
        r_rd       <= i_rd;
        r_rd_addr  <= i_rd_addr;
        r_wr_rd    <= i_wr_rd;
        r_pc       <= i_pc;
        r_killed   <= 1'b0;
      end else if (i_flush && w_cyc) begin
        r_killed <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ce         <= 1'b0;
      o_wr_rd      <= 1'b0;
      o_rd_addr    <= '0;
      o_rd         <= '0;
      o_pc         <= '0;
      o_misaligned <= 1'b0;
      o_bus_error  <= 1'b0;
      o_flush      <= 1'b0;
    end else begin
      o_flush <= i_flush;
      case (r_state)
        ST_IDLE: begin
          if (!i_stall) begin
            // Non-memory ops and misaligned accesses retire here; aligned ones go to the bus.
            o_ce         <= w_launch & ~(w_mem_op & ~w_mis);
            o_misaligned <= w_launch & w_mem_op & w_mis;
            o_bus_error  <= 1'b0;
            o_wr_rd      <= w_launch & i_wr_rd & ~w_mem_op;
            if (w_launch) begin
              o_rd      <= i_rd;
              o_rd_addr <= i_rd_addr;
              o_pc      <= i_pc;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (w_next == ST_DONE) begin
            o_ce         <= ~r_killed & ~i_flush;
            o_rd         <= (w_ack_ok && !r_is_store) ? w_ldata : r_rd;
            o_wr_rd      <= w_ack_ok & ~r_is_store & r_wr_rd & ~r_killed & ~i_flush;
            o_bus_error  <= w_to;
            o_misaligned <= 1'b0;
            o_rd_addr    <= r_rd_addr;
            o_pc         <= r_pc;
          end
        end
        ST_DONE: begin
          if (!i_stall) begin
            o_ce         <= 1'b0;
            o_wr_rd      <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
          end
        end
        default: o_ce <= 1'b0;
      endcase
    end
  end

endmodule
